// File: rtl/route_arbiter.sv
// 8x8 word router: one holding register per input port, independent round-robin
// arbitration per output FIFO, one-hot push lanes per output with zeroed idle lanes.
module route_arbiter (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    in_valid,
  input  logic [255:0]  in_data,
  output logic [7:0]    in_ready,
  input  logic [7:0]    fifo_full,
  output logic [63:0]   fifo_push,
  output logic [2047:0] fifo_din,
  output logic          busy
);

  localparam int unsigned NP = 8;
  localparam int unsigned NO = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 3;

  logic [NP-1:0] hold_v;
  logic [DW-1:0] hold_d [NP];
  logic [PW-1:0] rr_ptr [NO];

  logic [NP-1:0] req   [NO];
  logic [NP-1:0] grant [NO];
  logic [NO-1:0] gvld;
  logic [PW-1:0] gidx  [NO];
  logic [NP-1:0] grant_any;
  logic [NP-1:0] accept;

  // Request matrix: each held word asks for the output named by its top 3 bits
  always_comb begin
    for (int unsigned o = 0; o < NO; o++) begin
      for (int unsigned i = 0; i < NP; i++) begin
        req[o][i] = hold_v[i] && (hold_d[i][DW-1 -: PW] == PW'(o));
      end
    end
  end

  // Per-output round-robin: first requester at or after rr_ptr, skipped when full
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int unsigned o = 0; o < NO; o++) begin
      grant[o] = '0;
      gvld[o]  = 1'b0;
      gidx[o]  = '0;
      for (int unsigned k = 0; k < NP; k++) begin
        idx = PW'(rr_ptr[o] + PW'(k));
        if (!fifo_full[o] && !gvld[o] && req[o][idx]) begin
          grant[o][idx] = 1'b1;
          gvld[o]       = 1'b1;
          gidx[o]       = idx;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NP; i++) begin
      grant_any[i] = 1'b0;
      for (int unsigned o = 0; o < NO; o++) begin
        grant_any[i] = grant_any[i] | grant[o][i];
      end
    end
  end

  // A granted port frees its holding register this cycle, so it may accept again
  assign in_ready = ~hold_v | grant_any;
  assign accept   = in_valid & in_ready;
  assign busy     = |hold_v;

  // Idle lanes carry zero so downstream can OR-reduce a group of 8 lanes
  always_comb begin
    for (int unsigned o = 0; o < NO; o++) begin
      for (int unsigned i = 0; i < NP; i++) begin
        fifo_push[NP*o + i]             = grant[o][i];
        fifo_din[DW*(NP*o + i) +: DW]   = grant[o][i] ? hold_d[i] : '0;
      end
    end
  end

  // Holding registers: accept wins over grant so a port streams 1 word/cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_v <= '0;
      for (int unsigned i = 0; i < NP; i++) begin
        hold_d[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NP; i++) begin
        if (accept[i]) begin
          hold_v[i] <= 1'b1;
          hold_d[i] <= in_data[DW*i +: DW];
        end else if (grant_any[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned o = 0; o < NO; o++) begin
        rr_ptr[o] <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NO; o++) begin
        if (gvld[o]) begin
          rr_ptr[o] <= PW'(gidx[o] + PW'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_route_arbiter.sv
// Scoreboard bench for route_arbiter: per-port drivers feed words from queues,
// a monitor pops per-output expected (port, word) pairs on every push.
module tb_route_arbiter;

  logic          clk;
  logic          resetn;
  logic [7:0]    in_valid;
  logic [255:0]  in_data;
  logic [7:0]    in_ready;
  logic [7:0]    fifo_full;
  logic [63:0]   fifo_push;
  logic [2047:0] fifo_din;
  logic          busy;

  route_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .fifo_full (fifo_full),
    .fifo_push (fifo_push),
    .fifo_din  (fifo_din),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] txq   [8][$];
  logic [34:0] exp_q [8][$];
  logic        drv_v [8];
  logic [31:0] drv_d [8];
  int          last_acc_cyc  [8];
  int          last_push_cyc [8];

  always_comb begin
    for (int p = 0; p < 8; p++) begin
      in_valid[p]          = drv_v[p];
      in_data[32*p +: 32]  = drv_d[p];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Per-port driver: present head of queue, pop once the handshake completes
  for (genvar gp = 0; gp < 8; gp++) begin : g_drv
    initial begin
      logic acc;
      drv_v[gp] = 1'b0;
      drv_d[gp] = '0;
      last_acc_cyc[gp] = 0;
      forever begin
        @(negedge clk);
        acc = drv_v[gp] && in_ready[gp] && resetn;
        if (acc) last_acc_cyc[gp] = cyc + 1;
        @(posedge clk);
        #1;
        if (acc && txq[gp].size() > 0) void'(txq[gp].pop_front());
        if (txq[gp].size() > 0 && resetn) begin
          drv_v[gp] = 1'b1;
          drv_d[gp] = txq[gp][0];
        end else begin
          drv_v[gp] = 1'b0;
        end
      end
    end
  end

  // Monitor: every push must match the head of its output's expected queue
  initial begin
    logic [31:0] lane;
    logic [34:0] e;
    logic        bad;
    int          cnt;
    for (int o = 0; o < 8; o++) last_push_cyc[o] = 0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        bad = 1'b0;
        for (int o = 0; o < 8; o++) begin
          cnt = 0;
          for (int i = 0; i < 8; i++) begin
            lane = fifo_din[32*(8*o+i) +: 32];
            if (fifo_push[8*o+i]) begin
              cnt++;
              checks++;
              if (exp_q[o].size() == 0) begin
                errors++;
                $display("FAIL unexpected_push: out %0d port %0d word %h, none expected", o, i, lane);
              end else begin
                e = exp_q[o].pop_front();
                last_push_cyc[o] = cyc + 1;
                if (e !== {3'(i), lane}) begin
                  errors++;
                  $display("FAIL push_out%0d: got port %0d word %h expected port %0d word %h",
                           o, i, lane, e[34:32], e[31:0]);
                end
              end
            end else if (lane != 32'h0) begin
              bad = 1'b1;
            end
          end
          if (cnt > 1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL lanes: push %h has multi-grant group or nonzero idle lane", fifo_push);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < 8; k++) begin
      if (txq[k].size() != 0 || exp_q[k].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (n < 300 && pending()) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: words still pending after %0d cycles", n);
      for (int k = 0; k < 8; k++) begin
        txq[k].delete();
        exp_q[k].delete();
      end
    end
    step(3);
  endtask

  task automatic expect_word(input int o, input int p, input logic [31:0] w);
    exp_q[o].push_back({3'(p), w});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] w;
    resetn    = 1'b0;
    fifo_full = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'hFF);
    check("rst_busy",     64'(busy), 64'h0);
    check("rst_push",     fifo_push, 64'h0);
    check("rst_din_zero", 64'(fifo_din != '0), 64'h0);
    @(posedge clk);
    #2 resetn = 1'b1;
    step(2);

    // Single word port 3 -> output 2
    txq[3].push_back(32'h4000_00AA);
    expect_word(2, 3, 32'h4000_00AA);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fifo_push == '0 && n < 10);
    check("single_push_vec",  fifo_push, 64'h1 << 19);
    check("single_push_word", 64'(fifo_din[32*19 +: 32]), 64'h4000_00AA);
    drain();
    check("single_latency", 64'(last_push_cyc[2]), 64'(last_acc_cyc[3] + 1));

    // Ports 0,1,5 contend for output 0, rr_ptr starts at 0
    fifo_full[0] = 1'b1;
    step(1);
    txq[0].push_back(32'h0000_0A00); txq[0].push_back(32'h0000_0A01);
    txq[1].push_back(32'h0000_0B00); txq[1].push_back(32'h0000_0B01);
    txq[5].push_back(32'h0000_0C00); txq[5].push_back(32'h0000_0C01);
    expect_word(0, 0, 32'h0000_0A00);
    expect_word(0, 1, 32'h0000_0B00);
    expect_word(0, 5, 32'h0000_0C00);
    expect_word(0, 0, 32'h0000_0A01);
    expect_word(0, 1, 32'h0000_0B01);
    expect_word(0, 5, 32'h0000_0C01);
    step(4);
    @(negedge clk);
    check("rr_blocked_ready", 64'(in_ready & 8'b0010_0011), 64'h0);
    check("rr_blocked_busy",  64'(busy), 64'h1);
    check("rr_blocked_push",  fifo_push, 64'h0);
    step(1);
    fifo_full[0] = 1'b0;
    drain();

    // Full output 4 holds port 6 word, then rr_ptr[4] must be 7
    fifo_full[4] = 1'b1;
    step(1);
    txq[6].push_back(32'h8000_0066);
    expect_word(4, 6, 32'h8000_0066);
    step(4);
    @(negedge clk);
    check("full_hold_ready", 64'(in_ready[6]), 64'h0);
    check("full_hold_push",  fifo_push, 64'h0);
    check("full_hold_busy",  64'(busy), 64'h1);
    step(1);
    fifo_full[4] = 1'b0;
    drain();
    fifo_full[4] = 1'b1;
    step(1);
    txq[5].push_back(32'h8000_0055);
    txq[7].push_back(32'h8000_0077);
    expect_word(4, 7, 32'h8000_0077);
    expect_word(4, 5, 32'h8000_0055);
    step(4);
    fifo_full[4] = 1'b0;
    drain();

    // Pointer wrap on output 1: 6 -> ptr 7; then 7 before 0; then ptr 1
    txq[6].push_back(32'h2000_0016);
    expect_word(1, 6, 32'h2000_0016);
    drain();
    fifo_full[1] = 1'b1;
    step(1);
    txq[0].push_back(32'h2000_0010);
    txq[7].push_back(32'h2000_0017);
    expect_word(1, 7, 32'h2000_0017);
    expect_word(1, 0, 32'h2000_0010);
    step(4);
    fifo_full[1] = 1'b0;
    drain();
    fifo_full[1] = 1'b1;
    step(1);
    txq[0].push_back(32'h2000_0020);
    txq[1].push_back(32'h2000_0021);
    expect_word(1, 1, 32'h2000_0021);
    expect_word(1, 0, 32'h2000_0020);
    step(4);
    fifo_full[1] = 1'b0;
    drain();

    // All ports stream to a rotating permutation of outputs
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 8; p++) begin
        w = {3'((p + k) % 8), 13'h0, 8'(p), 8'(k)};
        txq[p].push_back(w);
      end
      for (int o = 0; o < 8; o++) begin
        int p;
        p = (o - k + 8) % 8;
        expect_word(o, p, {3'(o), 13'h0, 8'(p), 8'(k)});
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_valid != 8'hFF && n < 10);
    check("stream_ready_first", 64'(in_ready), 64'hFF);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("stream_ready", 64'(in_ready), 64'hFF);
      check("stream_push8", 64'($countones(fifo_push)), 64'd8);
    end
    drain();

    // Async reset while every holding register is occupied
    fifo_full = 8'hFF;
    step(1);
    for (int p = 0; p < 8; p++) txq[p].push_back({3'(p), 29'h0123_4567});
    step(5);
    @(negedge clk);
    check("prerst_busy",     64'(busy), 64'h1);
    check("prerst_in_ready", 64'(in_ready), 64'h0);
    #2 resetn = 1'b0;
    #1;
    check("arst_push",     fifo_push, 64'h0);
    check("arst_busy",     64'(busy), 64'h0);
    check("arst_in_ready", 64'(in_ready), 64'hFF);
    check("arst_din_zero", 64'(fifo_din != '0), 64'h0);
    step(2);
    resetn = 1'b1;
    step(1);
    @(negedge clk);
    check("postrst_busy", 64'(busy), 64'h0);
    step(1);
    // rr_ptr[2] was 6 before reset; after reset port 1 must win over port 7
    txq[7].push_back(32'h4000_0027);
    txq[1].push_back(32'h4000_0021);
    expect_word(2, 1, 32'h4000_0021);
    expect_word(2, 7, 32'h4000_0027);
    step(4);
    fifo_full = 8'h00;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
